// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: decode-stage hazard/issue control; define HAZARD_FWD_EN for forwarding+WB bypass, otherwise full interlock
module id_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             valid_id,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic             rs1_used,
   input  logic             rs2_used,
   input  logic [4:0]       rd,
   input  logic             reg_write_id,
   input  logic             mem_read_id,
   input  logic             redirect_ex,
   output logic             stall_if,
   output logic             stall_id,
   output logic             flush_id,
   output logic             bubble_ex,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             bypass_rs1,
   output logic             bypass_rs2,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       wen;
      logic       ld;
   } tag_t;

   tag_t ex_q, ex_d, mem_q, wb_q;
   logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d, sel_a, sel_b;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic a_ex, a_mem, a_wb, b_ex, b_mem, b_wb, hazard, issue;

   function automatic logic hit(input logic used, input logic [4:0] rs, input tag_t e);
      return used && rs != 5'd0 && e.v && e.wen && e.rd != 5'd0 && e.rd == rs;
   endfunction

   assign a_ex  = hit(rs1_used, rs1, ex_q);
   assign a_mem = hit(rs1_used, rs1, mem_q);
   assign a_wb  = hit(rs1_used, rs1, wb_q);
   assign b_ex  = hit(rs2_used, rs2, ex_q);
   assign b_mem = hit(rs2_used, rs2, mem_q);
   assign b_wb  = hit(rs2_used, rs2, wb_q);

`ifdef HAZARD_FWD_EN
   // only a load still in EX cannot be forwarded in time
   assign hazard     = ex_q.ld && (a_ex || b_ex);
   assign sel_a      = a_ex ? 2'b01 : a_mem ? 2'b10 : 2'b00;
   assign sel_b      = b_ex ? 2'b01 : b_mem ? 2'b10 : 2'b00;
   assign bypass_rs1 = a_wb;
   assign bypass_rs2 = b_wb;
`else
   // no forwarding: wait until the producer has left WB
   assign hazard     = a_ex || a_mem || a_wb || b_ex || b_mem || b_wb;
   assign sel_a      = 2'b00;
   assign sel_b      = 2'b00;
   assign bypass_rs1 = 1'b0;
   assign bypass_rs2 = 1'b0;
`endif

   assign stall_id  = valid_id && hazard && !redirect_ex;
   assign stall_if  = stall_id;
   assign flush_id  = redirect_ex;
   assign bubble_ex = stall_id || redirect_ex;
   assign issue     = valid_id && !stall_id && !redirect_ex && !freeze;
   assign fwd_a_sel = fwd_a_q;
   assign fwd_b_sel = fwd_b_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

   // next state: decode info enters EX on issue, counters saturate at all-ones
   always_comb begin
      ex_d        = issue ? {1'b1, rd, reg_write_id, mem_read_id} : '0;
      fwd_a_d     = issue ? sel_a : 2'b00;
      fwd_b_d     = issue ? sel_b : 2'b00;
      stall_cnt_d = (stall_id && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
      flush_cnt_d = (redirect_ex && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
   end

   // tag pipeline, select registers and counters; everything holds while frozen
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         fwd_a_q     <= 2'b00;
         fwd_b_q     <= 2'b00;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else if (!freeze) begin
         ex_q        <= ex_d;
         mem_q       <= ex_q;
         wb_q        <= mem_q;
         fwd_a_q     <= fwd_a_d;
         fwd_b_q     <= fwd_b_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: directed self-checking bench for id_hazard_ctrl (2-bit counters to reach saturation)
module tb_id_hazard_ctrl;
   localparam int W = 2;
   logic clk = 1'b0, rst, freeze, valid_id, rs1_used, rs2_used, reg_write_id, mem_read_id, redirect_ex;
   logic [4:0] rs1, rs2, rd;
   logic stall_if, stall_id, flush_id, bubble_ex, bypass_rs1, bypass_rs2;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   logic [W-1:0] stall_cnt, flush_cnt;
   int checks = 0, errors = 0;
   int exp_s = 0, exp_f = 0;

   id_hazard_ctrl #(.CNT_W(W)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .valid_id(valid_id),
      .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
      .rd(rd), .reg_write_id(reg_write_id), .mem_read_id(mem_read_id),
      .redirect_ex(redirect_ex), .stall_if(stall_if), .stall_id(stall_id),
      .flush_id(flush_id), .bubble_ex(bubble_ex), .fwd_a_sel(fwd_a_sel),
      .fwd_b_sel(fwd_b_sel), .bypass_rs1(bypass_rs1), .bypass_rs2(bypass_rs2),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [4:0] s1, input logic u1, input logic [4:0] s2,
                      input logic u2, input logic [4:0] d, input logic we, input logic ld, input logic re);
      valid_id = v; rs1 = s1; rs1_used = u1; rs2 = s2; rs2_used = u2;
      rd = d; reg_write_id = we; mem_read_id = ld; redirect_ex = re;
      #1;
   endtask

   task automatic idle();
      drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // es/ef: hand-derived stall/redirect expectation for the edge being taken
   task automatic tick(input bit es, input bit ef);
      if (rst) begin
         exp_s = 0;
         exp_f = 0;
      end else if (!freeze) begin
         if (es && exp_s < 3) exp_s++;
         if (ef && exp_f < 3) exp_f++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      idle();
      repeat (3) tick(1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; freeze = 1'b0;
      idle();
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      rst = 1'b0;
      #1;
      check("rst_stall_id", stall_id, 0);
      check("rst_stall_if", stall_if, 0);
      check("rst_flush_id", flush_id, 0);
      check("rst_bubble", bubble_ex, 0);
      check("rst_fwd_a", fwd_a_sel, 0);
      check("rst_fwd_b", fwd_b_sel, 0);
      check("rst_byp1", bypass_rs1, 0);
      check("rst_byp2", bypass_rs2, 0);
      check("rst_scnt", stall_cnt, 0);
      check("rst_fcnt", flush_cnt, 0);
      drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      check("redir_flush", flush_id, 1);
      check("redir_bubble", bubble_ex, 1);
      tick(1'b0, 1'b1);
      idle();
      check("redir_fcnt1", flush_cnt, exp_f);

`ifdef HAZARD_FWD_EN
      // add x5 ; add x6,x5 -> EX forward
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0);
      drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
      check("exfwd_stall", stall_id, 0);
      tick(1'b0, 1'b0);
      check("exfwd_a", fwd_a_sel, 2'b01);
      check("exfwd_b", fwd_b_sel, 2'b00);
      // x6 in EX, x5 in MEM: rs1=x6 -> 01, rs2=x5 -> 10
      drv(1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
      check("mix_stall", stall_id, 0);
      tick(1'b0, 1'b0);
      check("mix_a", fwd_a_sel, 2'b01);
      check("mix_b", fwd_b_sel, 2'b10);
      // two producers of x5: youngest wins
      drain();
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      drv(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0);
      check("young_b", fwd_b_sel, 2'b01);
      // lw x5 ; add x7,x5 -> one stall then select 10
      drain();
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b0);
      drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
      check("lu_stall", stall_id, 1);
      check("lu_stall_if", stall_if, 1);
      check("lu_bubble", bubble_ex, 1);
      tick(1'b1, 1'b0);
      check("lu_bub_sel", fwd_a_sel, 2'b00);
      check("lu_release", stall_id, 0);
      tick(1'b0, 1'b0);
      check("lu_fwd_a", fwd_a_sel, 2'b10);
      check("lu_scnt", stall_cnt, exp_s);
      // x9 producer reaches WB while its reader is in decode
      drain();
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0);
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0);
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0);
      drv(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
      check("byp_rs1", bypass_rs1, 1);
      check("byp_rs2", bypass_rs2, 1);
      check("byp_stall", stall_id, 0);
      tick(1'b0, 1'b0);
      check("byp_sel", fwd_a_sel, 2'b00);
      // freeze holds the load in EX: stall persists, counter holds
      drain();
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b0);
      freeze = 1'b1;
      drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      check("frz_scnt", stall_cnt, exp_s);
      freeze = 1'b0;
      #1;
      check("frz_hold", stall_id, 1);
      tick(1'b1, 1'b0);
      check("frz_scnt2", stall_cnt, exp_s);
`else
      // add x5 ; add x6,x5 -> three interlock stalls
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
      check("il_prod_stall", stall_id, 0);
      tick(1'b0, 1'b0);
      drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
      check("il_ex", stall_id, 1);
      check("il_ex_if", stall_if, 1);
      check("il_ex_bub", bubble_ex, 1);
      tick(1'b1, 1'b0);
      check("il_mem", stall_id, 1);
      tick(1'b1, 1'b0);
      check("il_wb", stall_id, 1);
      check("il_wb_byp", bypass_rs1, 0);
      tick(1'b1, 1'b0);
      check("il_release", stall_id, 0);
      tick(1'b0, 1'b0);
      check("il_sel", fwd_a_sel, 2'b00);
      check("il_scnt", stall_cnt, exp_s);
      // rs2 on x6 in EX; one more stall saturates the counter
      drv(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
      check("il_rs2", stall_id, 1);
      tick(1'b1, 1'b0);
      check("il_sat", stall_cnt, exp_s);
      // freeze keeps the producer in EX; two thawed cycles later it sits in WB
      drain();
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0);
      idle();
      freeze = 1'b1;
      repeat (3) tick(1'b0, 1'b0);
      freeze = 1'b0;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
      check("il_frz_hold", stall_id, 1);
      tick(1'b1, 1'b0);
      check("il_frz_gone", stall_id, 0);
      tick(1'b0, 1'b0);
`endif

      // lw x5 in EX, dependent in decode, redirect wins
      drain();
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b0);
      drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1);
      check("rd_flush", flush_id, 1);
      check("rd_stall", stall_id, 0);
      check("rd_bubble", bubble_ex, 1);
      tick(1'b0, 1'b1);
      check("rd_fcnt", flush_cnt, exp_f);
      check("rd_sel", fwd_a_sel, 2'b00);
      // redirect under freeze does not count
      freeze = 1'b1;
      drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      check("frz_flush", flush_id, 1);
      tick(1'b0, 1'b1);
      check("frz_fcnt", flush_cnt, exp_f);
      freeze = 1'b0;
      // flush counter saturation
      repeat (3) tick(1'b0, 1'b1);
      check("fcnt_sat", flush_cnt, exp_f);
      // writes to x0 never hazard, forward or bypass
      drain();
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b0);
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0);
      drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
      check("x0_stall", stall_id, 0);
      tick(1'b0, 1'b0);
      drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
      check("x0_byp1", bypass_rs1, 0);
      check("x0_byp2", bypass_rs2, 0);
      check("x0_fwd_a", fwd_a_sel, 2'b00);
      check("x0_fwd_b", fwd_b_sel, 2'b00);
      tick(1'b0, 1'b0);
      // reset during a load-use stall releases it
      drain();
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b0);
      drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
      check("mid_stall", stall_id, 1);
      rst = 1'b1;
      tick(1'b1, 1'b0);
      rst = 1'b0;
      #1;
      check("mid_release", stall_id, 0);
      check("mid_scnt", stall_cnt, exp_s);
      check("mid_fcnt", flush_cnt, exp_f);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Hazard and issue controller for the decode stage of the in-order 5-stage RV32I pipeline.
- Tracks the destination tags of instructions in flight in EX, MEM and WB.
- Decides each cycle whether the decode-stage instruction issues, stalls or is flushed.
- Produces registered operand-forwarding selects for EX and a same-cycle WB bypass for the decode-stage register-file read, whose write lands only at the clock edge.
- Sits beside decode; drives the IF/ID and ID/EX pipeline-register controls.

## Interface
Parameters:
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- freeze  in  1  global hold (memory wait); all internal state holds
- valid_id  in  1  decode slot holds a real instruction
- rs1 / rs2  in  5  source register indices in decode
- rs1_used / rs2_used  in  1  instruction actually reads rs1 / rs2
- rd  in  5  destination index in decode
- reg_write_id  in  1  decode instruction writes rd
- mem_read_id  in  1  decode instruction is a load
- redirect_ex  in  1  taken branch or jump resolved in EX
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- flush_id  out  1  invalidate IF/ID register
- bubble_ex  out  1  load NOP into ID/EX instead of the decode instruction
- fwd_a_sel / fwd_b_sel  out  2  EX operand source: 00 register value, 01 EX/MEM result, 10 MEM/WB result (registered)
- bypass_rs1 / bypass_rs2  out  1  replace the decode read value with wb_data this cycle
- stall_cnt / flush_cnt  out  CNT_W  saturating event counters

## Operation
- Tag pipeline: three entries (EX, MEM, WB), each holding {valid, rd, wen, load}. An entry is "writing" when valid && wen && rd != 0.
- issue = valid_id && !stall_id && !redirect_ex && !freeze.
- Per edge, when !freeze:
  - WB <= MEM; MEM <= EX.
  - EX <= decode info if issue, else invalid.
- Match rule: rsX matches an entry when rsX_used && rsX != 0 && the entry is writing && entry.rd == rsX.
- Load-use stall: either source matches EX and EX.load = 1.
- stall_id = stall_if = valid_id && load-use && !redirect_ex. bubble_ex = stall_id || redirect_ex.
- redirect_ex has priority over stall: flush_id = 1, bubble_ex = 1, stall_id = 0, and the decode instruction is discarded.
- Forward selects: captured at issue. Per operand, a match on EX gives 01; else a match on MEM gives 10; else 00. Youngest producer wins. On a bubble, the selects load 00.
- Bypass: bypass_rsX = rsX matches the WB entry (combinational). The decode read is stale because the register-file write is not yet visible.
- Counters:
  - stall_cnt +1 on each non-frozen cycle with stall_id = 1.
  - flush_cnt +1 on each non-frozen cycle with redirect_ex = 1.
  - Both saturate at all-ones.
- freeze: the tag pipeline, select registers and counters all hold. Combinational outputs still reflect current inputs.

## Timing
- Reset values:
  - All tag entries invalid; fwd selects 00; counters 0.
  - Combinational outputs are therefore 0 in the first cycle after reset (no writing entries), except flush_id and bubble_ex, which follow redirect_ex.
- Load-use costs exactly 1 stall cycle. The load then sits in MEM, and the dependent instruction issues with select 01... no: with select 10, because at issue the load is in MEM (its result arrives from MEM/WB when the consumer reaches EX).
- Redirect costs 1 bubble from this block (decode slot killed). Fetch-side kill is owned by IF.
- Forward selects are valid during the cycle the instruction occupies EX, i.e. one cycle after issue.
- Reset asserted mid-stall: next cycle all entries are invalid and stall is released.
- rd = x0 never creates a hazard, a forward or a bypass.

## Configuration
- HAZARD_FWD_EN defined: forwarding and bypass behave as above.
- HAZARD_FWD_EN undefined: full interlock.
  - stall_id asserts while any source matches EX, MEM or WB (any writing entry, load or not).
  - fwd selects are tied to 00; bypass outputs are tied to 0.
  - Redirect priority and the counters are unchanged.

## Test plan
- add x5 then add x6,x5: EX-entry match gives fwd_a_sel = 01 in the consumer's EX cycle; no stall.
- lw x5 then add x7,x5: 1 cycle of stall_id/bubble_ex; consumer issues with fwd_a_sel = 10; stall_cnt = 1.
- Producer to x9, then two unrelated instructions, then reader of x9 in decode while the producer is in WB: bypass_rs1 = 1, no stall.
- lw x5 in EX while a dependent instruction is in decode and redirect_ex = 1: flush_id = 1, stall_id = 0, flush_cnt = 1.
- Writes to x0 followed by a reader of x0: all selects 00, no stall, no bypass.
- With HAZARD_FWD_EN undefined, add x5 then add x6,x5: 3 stall cycles, then issue with select 00; stall_cnt = 3.
